// File: rtl/mdbrot_pkg.sv
// Shared constants, fixed-point types and helpers for the Mandelbrot renderer.
// Optional build macro MDBROT_ROW_HEX_EN (used by the top) puts the current row on HEX1:HEX0.
package mdbrot_pkg;

  localparam int W        = 24;       // Q8.16 signed datapath
  localparam int FRAC     = 16;
  localparam int MAX_ITER = 16;
  localparam int X_MIN    = -131072;  // -2.0
  localparam int Y_MAX    = 73728;    // +1.125
  localparam int STEP     = 1229;     // 3/160
  localparam int H_RES    = 160;
  localparam int V_RES    = 120;
  localparam int IW       = $clog2(MAX_ITER + 1);

  typedef logic signed [W-1:0]   fx_t;
  typedef logic signed [2*W-1:0] fx2_t;

  typedef enum logic [1:0] {S_INIT, S_ITER, S_PLOT, S_DONE} state_t;

  // In-set pixels are black; escaped pixels cycle through the seven other colours.
  function automatic logic [2:0] iter_colour(input logic [IW-1:0] it);
    if (it == IW'(MAX_ITER)) return 3'd0;
    return 3'(it % IW'(7)) + 3'd1;
  endfunction

  // Hex digit to active-low seven-segment pattern (gfedcba).
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

endpackage

// File: rtl/mdbrot_iter.sv
// One z = z^2 + c step plus the |z|^2 > 4 escape test, purely combinational.
// Products are kept at full 2W width before the arithmetic shift back to Q8.16.
module mdbrot_iter import mdbrot_pkg::*; (
  input  fx_t  zr,
  input  fx_t  zi,
  input  fx_t  cr,
  input  fx_t  ci,
  output fx_t  zr_nx,
  output fx_t  zi_nx,
  output logic escape
);

  fx2_t p_rr, p_ii, p_ri;
  fx2_t zr2, zi2, mag;
  fx2_t zr_full, zi_full;
  logic unused_hi;

  assign p_rr = fx2_t'(zr) * fx2_t'(zr);
  assign p_ii = fx2_t'(zi) * fx2_t'(zi);
  assign p_ri = fx2_t'(zr) * fx2_t'(zi);

  assign zr2  = p_rr >>> FRAC;
  assign zi2  = p_ii >>> FRAC;
  assign mag  = zr2 + zi2;

  assign escape = mag > fx2_t'(4 <<< FRAC);

  // (2*zr*zi) >>> FRAC is the same as the product shifted one place less
  assign zr_full = zr2 - zi2 + fx2_t'(cr);
  assign zi_full = (p_ri >>> (FRAC - 1)) + fx2_t'(ci);

  // Pre-escape |z| <= 2 keeps the next z well inside Q8.16, so truncation is exact
  assign zr_nx = zr_full[W-1:0];
  assign zi_nx = zi_full[W-1:0];

  assign unused_hi = ^{zr_full[2*W-1:W], zi_full[2*W-1:W]};

endmodule

// File: rtl/vga_adapter.sv
// Framebuffered VGA adapter: 160x120x3 pixel store written by the plot strobe,
// scanned out 4x upscaled on a 640x480 raster using a 25 MHz pixel enable.
module vga_adapter (
  input  logic       resetn,
  input  logic       clock,
  input  logic [2:0] colour,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic       plot,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_CLK
);

  localparam int H_TOT = 800;
  localparam int V_TOT = 525;

  logic [2:0]  fb [0:19199];
  logic [9:0]  hc, vc;
  logic        pix_en, active, active_d;
  logic [2:0]  rd;
  logic [14:0] wr_addr, rd_addr;

  assign wr_addr = 15'(y) * 15'd160 + 15'(x);
  assign rd_addr = 15'(vc[8:2]) * 15'd160 + 15'(hc[9:2]);
  assign active  = (hc < 10'd640) && (vc < 10'd480);

  // framebuffer write port, ignoring off-screen coordinates
  always_ff @(posedge clock)
    if (plot && (x < 8'd160) && (y < 7'd120)) fb[wr_addr] <= colour;

  // framebuffer read port, only inside the visible window
  always_ff @(posedge clock)
    if (pix_en && active) rd <= fb[rd_addr];

  // pixel enable and raster counters
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pix_en <= 1'b0;
      hc     <= '0;
      vc     <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (hc == 10'(H_TOT - 1)) begin
          hc <= '0;
          vc <= (vc == 10'(V_TOT - 1)) ? '0 : vc + 10'd1;
        end else begin
          hc <= hc + 10'd1;
        end
      end
    end
  end

  // registered syncs and blanking
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      VGA_HS   <= 1'b1;
      VGA_VS   <= 1'b1;
      active_d <= 1'b0;
    end else if (pix_en) begin
      VGA_HS   <= !((hc >= 10'd656) && (hc < 10'd752));
      VGA_VS   <= !((vc >= 10'd490) && (vc < 10'd492));
      active_d <= active;
    end
  end

  assign VGA_R   = active_d ? {8{rd[2]}} : 8'd0;
  assign VGA_G   = active_d ? {8{rd[1]}} : 8'd0;
  assign VGA_B   = active_d ? {8{rd[0]}} : 8'd0;
  assign VGA_CLK = pix_en;

endmodule

// File: rtl/mdbrot_top_single_nozoom.sv
// Mandelbrot renderer, one iteration engine, fixed viewport. Walks the 160x120
// frame in raster order after reset, plots one colour per pixel, then flags done.
// ROWS / IM0 default to the full frame and c_im at the top row.
// Build macro MDBROT_ROW_HEX_EN: HEX1:HEX0 show the current row in hex.
module mdbrot_top_single_nozoom import mdbrot_pkg::*; #(
  parameter int ROWS = V_RES,
  parameter int IM0  = Y_MAX
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_CLK,
  output logic [7:0] VGA_X,
  output logic [6:0] VGA_Y,
  output logic [2:0] VGA_COLOUR,
  output logic       VGA_PLOT
);

  logic          rst_n;
  state_t        state;
  logic [7:0]    x;
  logic [6:0]    y;
  fx_t           zr, zi, cr, ci;
  fx_t           zr_nx, zi_nx;
  logic          esc;
  logic [IW-1:0] iter;
  logic          done;
  logic          unused_in;

  assign rst_n     = KEY[3];
  assign unused_in = ^{KEY[2:0], SW};

  mdbrot_iter u_iter (
    .zr     (zr),
    .zi     (zi),
    .cr     (cr),
    .ci     (ci),
    .zr_nx  (zr_nx),
    .zi_nx  (zi_nx),
    .escape (esc)
  );

  // pixel FSM: seed c, iterate until escape or cap, emit one plot strobe, advance
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_INIT;
      x          <= '0;
      y          <= '0;
      zr         <= '0;
      zi         <= '0;
      cr         <= '0;
      ci         <= '0;
      iter       <= '0;
      done       <= 1'b0;
      VGA_PLOT   <= 1'b0;
      VGA_X      <= '0;
      VGA_Y      <= '0;
      VGA_COLOUR <= '0;
    end else begin
      case (state)
        S_INIT: begin
          cr    <= fx_t'(X_MIN + int'(x) * STEP);
          ci    <= fx_t'(IM0 - int'(y) * STEP);
          zr    <= '0;
          zi    <= '0;
          iter  <= '0;
          state <= S_ITER;
        end
        S_ITER: begin
          if (esc || iter == IW'(MAX_ITER)) begin
            VGA_PLOT   <= 1'b1;
            VGA_X      <= x;
            VGA_Y      <= y;
            VGA_COLOUR <= iter_colour(iter);
            state      <= S_PLOT;
          end else begin
            zr   <= zr_nx;
            zi   <= zi_nx;
            iter <= iter + IW'(1);
          end
        end
        S_PLOT: begin
          VGA_PLOT <= 1'b0;
          if (x == 8'(H_RES - 1)) begin
            x <= '0;
            if (y == 7'(ROWS - 1)) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              y     <= y + 7'd1;
              state <= S_INIT;
            end
          end else begin
            x     <= x + 8'd1;
            state <= S_INIT;
          end
        end
        default: VGA_PLOT <= 1'b0;
      endcase
    end
  end

  assign LEDR = {done, 2'b00, y};

`ifdef MDBROT_ROW_HEX_EN
  // current row on HEX1:HEX0, upper displays blank
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      HEX0 <= 7'h7F;
      HEX1 <= 7'h7F;
      HEX2 <= 7'h7F;
      HEX3 <= 7'h7F;
      HEX4 <= 7'h7F;
      HEX5 <= 7'h7F;
    end else begin
      HEX0 <= hex7(y[3:0]);
      HEX1 <= hex7({1'b0, y[6:4]});
      HEX2 <= 7'h7F;
      HEX3 <= 7'h7F;
      HEX4 <= 7'h7F;
      HEX5 <= 7'h7F;
    end
  end
`else
  assign HEX0 = 7'h7F;
  assign HEX1 = 7'h7F;
  assign HEX2 = 7'h7F;
  assign HEX3 = 7'h7F;
  assign HEX4 = 7'h7F;
  assign HEX5 = 7'h7F;
`endif

  vga_adapter u_vga (
    .resetn  (rst_n),
    .clock   (CLOCK_50),
    .colour  (VGA_COLOUR),
    .x       (VGA_X),
    .y       (VGA_Y),
    .plot    (VGA_PLOT),
    .VGA_R   (VGA_R),
    .VGA_G   (VGA_G),
    .VGA_B   (VGA_B),
    .VGA_HS  (VGA_HS),
    .VGA_VS  (VGA_VS),
    .VGA_CLK (VGA_CLK)
  );

endmodule

// File: tb/tb_mdbrot_top_single_nozoom.sv
// Bench for mdbrot_top_single_nozoom. dut_a renders the real viewport (start of
// frame, raster wrap, mid-frame resets); dut_b renders a two-row strip through
// the real axis (rows 60/61 of the frame) so a whole short frame finishes quickly.
module tb_mdbrot_top_single_nozoom;

  localparam int IM0_B  = 73728 - 60 * 1229;
  localparam int ROWS_B = 2;

  logic       clk = 1'b0;
  always #10 clk = ~clk;

  logic [3:0] key_a, key_b;
  logic [9:0] sw;

  logic [9:0] ledr_a, ledr_b;
  logic [6:0] hex_a [6];
  logic [6:0] hex_b [6];
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic       hs_a, vs_a, vclk_a, hs_b, vs_b, vclk_b;
  logic [7:0] x_a, x_b;
  logic [6:0] y_a, y_b;
  logic [2:0] col_a, col_b;
  logic       plot_a, plot_b;

  mdbrot_top_single_nozoom dut_a (
    .CLOCK_50(clk), .KEY(key_a), .SW(sw), .LEDR(ledr_a),
    .HEX0(hex_a[0]), .HEX1(hex_a[1]), .HEX2(hex_a[2]), .HEX3(hex_a[3]), .HEX4(hex_a[4]), .HEX5(hex_a[5]),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a), .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_CLK(vclk_a),
    .VGA_X(x_a), .VGA_Y(y_a), .VGA_COLOUR(col_a), .VGA_PLOT(plot_a)
  );

  mdbrot_top_single_nozoom #(.ROWS(ROWS_B), .IM0(IM0_B)) dut_b (
    .CLOCK_50(clk), .KEY(key_b), .SW(sw), .LEDR(ledr_b),
    .HEX0(hex_b[0]), .HEX1(hex_b[1]), .HEX2(hex_b[2]), .HEX3(hex_b[3]), .HEX4(hex_b[4]), .HEX5(hex_b[5]),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_CLK(vclk_b),
    .VGA_X(x_b), .VGA_Y(y_b), .VGA_COLOUR(col_b), .VGA_PLOT(plot_b)
  );

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // escape-time reference in plain wide integer arithmetic
  function automatic int ref_iters(input int px, input int py, input int im0);
    longint cr, ci, zr, zi, zr2, zi2, t;
    cr = -131072 + px * 1229;
    ci = im0 - py * 1229;
    zr = 0;
    zi = 0;
    for (int it = 0; it <= 16; it++) begin
      zr2 = (zr * zr) >>> 16;
      zi2 = (zi * zi) >>> 16;
      if (zr2 + zi2 > 4 * 65536 || it == 16) return it;
      t  = ((2 * zr * zi) >>> 16) + ci;
      zr = zr2 - zi2 + cr;
      zi = t;
    end
    return 16;
  endfunction

  function automatic int ref_colour(input int it);
    return (it == 16) ? 0 : (it % 7) + 1;
  endfunction

  // per-DUT scoreboard: expected next pixel, cycles since last strobe, strobe count
  int   sb_x [2], sb_y [2], sb_cyc [2], sb_cnt [2], last_x [2], last_y [2];
  logic sb_prev [2];
  int   wrap_ok = 0, col107 = -1;
  int   first_x = -1, first_y = -1, first_col = -1, first_lat = -1;

  task automatic mon(input int d, input logic rstn, input logic plot, input int px,
                     input int py, input int col, input logic [9:0] ledr);
    int it, rows, im0;
    rows = (d == 0) ? 120 : ROWS_B;
    im0  = (d == 0) ? 73728 : IM0_B;
    if (!rstn) begin
      sb_x[d] = 0; sb_y[d] = 0; sb_cyc[d] = 1; sb_cnt[d] = 0; sb_prev[d] = 1'b0;
      return;
    end
    sb_cyc[d]++;
    if (plot) begin
      if (sb_cnt[d] == 160 * rows) begin
        check("extra_plot", 1, 0);
      end else begin
        it = ref_iters(sb_x[d], sb_y[d], im0);
        check("px_x", px, sb_x[d]);
        check("px_y", py, sb_y[d]);
        check("colour", col, ref_colour(it));
        check("latency", sb_cyc[d], it + 3);
        check("back_to_back", int'(sb_prev[d]), 0);
        check("ledr_row", int'(ledr[6:0]), sb_y[d]);
        check("ledr_done_early", int'(ledr[9]), 0);
        if (d == 0 && sb_cnt[d] == 0) begin
          first_x = px; first_y = py; first_col = col; first_lat = sb_cyc[d] - 1;
        end
        if (d == 0 && px == 0 && py == 1) wrap_ok = (last_x[0] == 159 && last_y[0] == 0) ? 1 : 0;
        if (d == 1 && sb_x[d] == 107 && sb_y[d] == 0) col107 = col;
        last_x[d] = px;
        last_y[d] = py;
        sb_cnt[d]++;
        if (sb_x[d] == 159) begin sb_x[d] = 0; sb_y[d]++; end
        else sb_x[d]++;
      end
      sb_cyc[d] = 0;
    end
    sb_prev[d] = plot;
  endtask

  always @(negedge clk) begin
    mon(0, key_a[3], plot_a, int'(x_a), int'(y_a), int'(col_a), ledr_a);
    mon(1, key_b[3], plot_b, int'(x_b), int'(y_b), int'(col_b), ledr_b);
  end

  initial begin
    int n, cnt;
    key_a = 4'hF;
    key_b = 4'hF;
    key_a[2:0] = 3'($urandom);
    key_b[2:0] = 3'($urandom);
    sw = 10'($urandom);
    #3;
    key_a[3] = 1'b0;
    key_b[3] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_plot", int'(plot_a), 0);
    check("rst_x", int'(x_a), 0);
    check("rst_y", int'(y_a), 0);
    check("rst_colour", int'(col_a), 0);
    check("rst_ledr", int'(ledr_a), 0);
    check("rst_ledr_b", int'(ledr_b), 0);
    for (int i = 0; i < 6; i++) check("rst_hex", int'(hex_a[i]), 'h7F);

    @(negedge clk);
    #2;
    key_a[3] = 1'b1;
    key_b[3] = 1'b1;

    // short frame on dut_b must complete, with the (107,60) pixel in-set
    n = 0;
    while (!ledr_b[9] && n < 20000) begin @(posedge clk); #1; n++; end
    check("b_done_seen", int'(ledr_b[9]), 1);
    check("b_strobe_count", sb_cnt[1], 160 * ROWS_B);
    check("col_107_60", col107, 0);
    cnt = 0;
    repeat (50) begin @(posedge clk); #1; if (plot_b) cnt++; end
    check("b_no_plot_after_done", cnt, 0);
    check("b_done_held", int'(ledr_b[9]), 1);

    // dut_a: first pixel and row wrap
    n = 0;
    while (sb_cnt[0] < 161 && n < 20000) begin @(posedge clk); n++; end
    check("a_reached_row1", int'(sb_cnt[0] >= 161), 1);
    check("first_xy", first_x * 256 + first_y, 0);
    check("first_colour", first_col, 2);
    check("first_latency", first_lat, 3);
    check("wrap_159_0_to_0_1", wrap_ok, 1);
    for (int i = 2; i < 6; i++) check("run_hex_blank", int'(hex_a[i]), 'h7F);

    // mid-frame reset aborts at once and restarts at (0,0)
    for (int r = 0; r < 2; r++) begin
      repeat ($urandom_range(20, 400)) @(posedge clk);
      @(negedge clk);
      #3;
      key_a[3] = 1'b0;
      #1;
      check("midrst_plot", int'(plot_a), 0);
      check("midrst_ledr", int'(ledr_a), 0);
      check("midrst_xy", int'(x_a) * 256 + int'(y_a), 0);
      first_x = -1;
      first_y = -1;
      repeat (2) @(negedge clk);
      #2;
      key_a[3] = 1'b1;
      n = 0;
      while (sb_cnt[0] < 1 && n < 200) begin @(posedge clk); n++; end
      check("restart_seen", int'(sb_cnt[0] >= 1), 1);
      check("restart_xy", first_x * 256 + first_y, 0);
    end

    repeat (20) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
